control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; all enumerated types (alu_op_e, alu_src_a_e, alu_src_b_e, mem_size_e, immediate_type_e, pc_src_e, result_src_e) and opcode/funct3 constants SHALL be taken from riscv_pkg.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 opcode  in  7  instruction[6:0].
REQ-006 funct3  in  3  instruction[14:12].
REQ-007 funct7  in  7  instruction[31:25].
REQ-008 zero_flag, negative_flag, carry_flag, overflow_flag  in  1 each  comparison flags for rs1 - rs2 (carry_flag=1 means rs1 < rs2 unsigned).
REQ-009 alu_control  out  alu_op_e  ALU operation.
REQ-010 alu_src_a_sel  out  alu_src_a_e  RS1 / PC / ZERO.
REQ-011 alu_src_b_sel  out  alu_src_b_e  RS2 / IMM.
REQ-012 reg_write_enable  out  1  register-file write enable.
REQ-013 mem_read, mem_write  out  1 each  data-memory strobes.
REQ-014 mem_size  out  mem_size_e  BYTE / HALF / WORD.
REQ-015 mem_usign_load  out  1  zero-extend load data.
REQ-016 imm_src  out  immediate_type_e  IMM_I/S/B/U/J.
REQ-017 pc_src  out  pc_src_e  PC4 / BRANCH_JAL / JALR.
REQ-018 result_src  out  result_src_e  ALU / MEM / PC4.

Function
REQ-019 Decode SHALL be purely combinational from current inputs (zero latency), gated only by the reset flag of REQ-031.
REQ-020 NOP defaults (any unlisted field): ALU_ADD, A=RS1, B=RS2, no reg write, no mem access, MEM_WORD, usign=0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU.
REQ-021 LUI: ALU_ADD, A=ZERO, B=IMM, IMM_U, reg write, result ALU.
REQ-022 AUIPC: ALU_AUIPC, A=PC, B=IMM, IMM_U, reg write, result ALU.
REQ-023 JAL: ALU_ADD, A=PC, B=IMM, IMM_J, reg write, PC_SRC_BRANCH_JAL, result PC4.
REQ-024 JALR: ALU_ADD, A=RS1, B=IMM, IMM_I, reg write, PC_SRC_JALR, result PC4.
REQ-025 BRANCH: ALU_ADD, A=RS1, B=RS2, IMM_B, no reg write; pc_src=BRANCH_JAL when taken else PC4; taken: BEQ zero, BNE !zero, BLT negative^overflow, BGE !(negative^overflow), BLTU carry, BGEU !carry; funct3 010/011 never taken.
REQ-026 LOAD: ALU_ADD, A=RS1, B=IMM, IMM_I, reg write, mem_read, result MEM; funct3 000 BYTE signed, 001 HALF signed, 010 WORD, 100 BYTE unsigned, 101 HALF unsigned; other funct3 -> NOP.
REQ-027 STORE: ALU_ADD, A=RS1, B=IMM, IMM_S, mem_write, no reg write; funct3 000 BYTE, 001 HALF, 010 WORD; other -> NOP.
REQ-028 OP-IMM: A=RS1, B=IMM, IMM_I, reg write, result ALU; funct3 -> ADD, SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND; ADDI ignores funct7.
REQ-029 OP (R-type): A=RS1, B=RS2, reg write, result ALU; same mapping, funct3 000 with funct7[5]=1 -> SUB.
REQ-030 Unknown opcode -> NOP defaults; outputs never X for known inputs.

Reset
REQ-031 Internal flag ready SHALL clear at a rising clk with rst_n=0 and set at the first rising clk with rst_n=1.
REQ-032 While ready=0 all outputs SHALL be NOP defaults (REQ-020) regardless of inputs; reset asserted mid-instruction forces NOP from the next edge.

Verification
REQ-033 LUI after reset release -> ALU_ADD, A=ZERO, B=IMM, IMM_U, reg_write=1, PC4, result ALU.
REQ-034 BEQ with zero_flag=1 -> pc_src BRANCH_JAL, reg_write=0, IMM_B; zero_flag=0 -> PC4.
REQ-035 LW -> mem_read=1, MEM_WORD, usign=0, result MEM; LBU -> MEM_BYTE, usign=1.
REQ-036 JALR -> A=RS1, B=IMM, IMM_I, PC_SRC_JALR, result PC4, reg_write=1.
REQ-037 R-type funct3=101 funct7=0100000 -> ALU_SRA; OPCODE_STORE SW -> mem_write=1, IMM_S, reg_write=0.
REQ-038 rst_n=0 at a clk edge while opcode=OPCODE_STORE -> mem_write=0, reg_write=0 until the first edge with rst_n=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types and opcode/funct3 constants used by
// the control unit and anything that consumes its control outputs.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_AUIPC = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_SRC_A_RS1  = 2'd0,
        ALU_SRC_A_PC   = 2'd1,
        ALU_SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic {
        ALU_SRC_B_RS2 = 1'b0,
        ALU_SRC_B_IMM = 1'b1
    } alu_src_b_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } immediate_type_e;

    typedef enum logic [1:0] {
        PC_SRC_PC4        = 2'd0,
        PC_SRC_BRANCH_JAL = 2'd1,
        PC_SRC_JALR       = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU = 2'd0,
        RESULT_SRC_MEM = 2'd1,
        RESULT_SRC_PC4 = 2'd2
    } result_src_e;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields and comparison flags into the decoder,
// datapath control signals out of it.
//   master : drives opcode/funct3/funct7/flags, receives controls
//   slave  : the control unit itself
interface control_unit_if;
    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            zero_flag;
    logic            negative_flag;
    logic            carry_flag;     // 1 = rs1 < rs2 unsigned
    logic            overflow_flag;

    alu_op_e         alu_control;
    alu_src_a_e      alu_src_a_sel;
    alu_src_b_e      alu_src_b_sel;
    logic            reg_write_enable;
    logic            mem_read;
    logic            mem_write;
    mem_size_e       mem_size;
    logic            mem_usign_load;
    immediate_type_e imm_src;
    pc_src_e         pc_src;
    result_src_e     result_src;

    modport master (
        output opcode, funct3, funct7,
        output zero_flag, negative_flag, carry_flag, overflow_flag,
        input  alu_control, alu_src_a_sel, alu_src_b_sel, reg_write_enable,
        input  mem_read, mem_write, mem_size, mem_usign_load,
        input  imm_src, pc_src, result_src
    );

    modport slave (
        input  opcode, funct3, funct7,
        input  zero_flag, negative_flag, carry_flag, overflow_flag,
        output alu_control, alu_src_a_sel, alu_src_b_sel, reg_write_enable,
        output mem_read, mem_write, mem_size, mem_usign_load,
        output imm_src, pc_src, result_src
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: single-cycle RV32I main decoder.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - control_unit_if.slave: opcode/funct3/funct7 and rs1-rs2
//           comparison flags in; ALU, memory, immediate, PC and writeback
//           controls out.
// Decode is combinational from the current inputs. The only state is a
// ready flag that forces NOP controls from a reset edge until the first
// edge after reset is released, so nothing writes state during reset.
module control_unit
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.slave bus
);

    logic ready_q, ready_d;

    always_comb begin
        ready_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= ready_d;
    end

    // funct3 -> ALU op shared by OP and OP-IMM; sub_sel is only honoured
    // for R-type (ADDI has no SUB form), sra_sel for both.
    function automatic alu_op_e arith_op(input logic [2:0] f3,
                                         input logic       sub_sel,
                                         input logic       sra_sel);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = sub_sel ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = sra_sel ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    alu_op_e         alu_d;
    alu_src_a_e      src_a_d;
    alu_src_b_e      src_b_d;
    logic            reg_write_d;
    logic            mem_read_d;
    logic            mem_write_d;
    mem_size_e       mem_size_d;
    logic            usign_d;
    immediate_type_e imm_d;
    pc_src_e         pc_src_d;
    result_src_e     result_d;
    logic            taken;
    logic            signed_lt;

    // negative^overflow is the signed-less-than result of rs1 - rs2.
    assign signed_lt = bus.negative_flag ^ bus.overflow_flag;

    always_comb begin
        alu_d       = ALU_ADD;
        src_a_d     = ALU_SRC_A_RS1;
        src_b_d     = ALU_SRC_B_RS2;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_size_d  = MEM_WORD;
        usign_d     = 1'b0;
        imm_d       = IMM_I;
        pc_src_d    = PC_SRC_PC4;
        result_d    = RESULT_SRC_ALU;
        taken       = 1'b0;

        if (ready_q) begin
            case (bus.opcode)
                OPCODE_LUI: begin
                    src_a_d     = ALU_SRC_A_ZERO;
                    src_b_d     = ALU_SRC_B_IMM;
                    imm_d       = IMM_U;
                    reg_write_d = 1'b1;
                end
                OPCODE_AUIPC: begin
                    alu_d       = ALU_AUIPC;
                    src_a_d     = ALU_SRC_A_PC;
                    src_b_d     = ALU_SRC_B_IMM;
                    imm_d       = IMM_U;
                    reg_write_d = 1'b1;
                end
                OPCODE_JAL: begin
                    src_a_d     = ALU_SRC_A_PC;
                    src_b_d     = ALU_SRC_B_IMM;
                    imm_d       = IMM_J;
                    reg_write_d = 1'b1;
                    pc_src_d    = PC_SRC_BRANCH_JAL;
                    result_d    = RESULT_SRC_PC4;
                end
                OPCODE_JALR: begin
                    src_b_d     = ALU_SRC_B_IMM;
                    imm_d       = IMM_I;
                    reg_write_d = 1'b1;
                    pc_src_d    = PC_SRC_JALR;
                    result_d    = RESULT_SRC_PC4;
                end
                OPCODE_BRANCH: begin
                    imm_d = IMM_B;
                    case (bus.funct3)
                        F3_BEQ:  taken = bus.zero_flag;
                        F3_BNE:  taken = !bus.zero_flag;
                        F3_BLT:  taken = signed_lt;
                        F3_BGE:  taken = !signed_lt;
                        F3_BLTU: taken = bus.carry_flag;
                        F3_BGEU: taken = !bus.carry_flag;
                        default: taken = 1'b0;
                    endcase
                    pc_src_d = taken ? PC_SRC_BRANCH_JAL : PC_SRC_PC4;
                end
                OPCODE_LOAD: begin
                    // Reserved widths fall through as a NOP.
                    if (bus.funct3 == F3_LB || bus.funct3 == F3_LH ||
                        bus.funct3 == F3_LW || bus.funct3 == F3_LBU ||
                        bus.funct3 == F3_LHU) begin
                        src_b_d     = ALU_SRC_B_IMM;
                        reg_write_d = 1'b1;
                        mem_read_d  = 1'b1;
                        result_d    = RESULT_SRC_MEM;
                        usign_d     = bus.funct3[2];
                        case (bus.funct3[1:0])
                            2'b00:   mem_size_d = MEM_BYTE;
                            2'b01:   mem_size_d = MEM_HALF;
                            default: mem_size_d = MEM_WORD;
                        endcase
                    end
                end
                OPCODE_STORE: begin
                    if (bus.funct3 == F3_SB || bus.funct3 == F3_SH ||
                        bus.funct3 == F3_SW) begin
                        src_b_d     = ALU_SRC_B_IMM;
                        imm_d       = IMM_S;
                        mem_write_d = 1'b1;
                        case (bus.funct3[1:0])
                            2'b00:   mem_size_d = MEM_BYTE;
                            2'b01:   mem_size_d = MEM_HALF;
                            default: mem_size_d = MEM_WORD;
                        endcase
                    end
                end
                OPCODE_OP_IMM: begin
                    alu_d       = arith_op(bus.funct3, 1'b0, bus.funct7[5]);
                    src_b_d     = ALU_SRC_B_IMM;
                    reg_write_d = 1'b1;
                end
                OPCODE_OP: begin
                    alu_d       = arith_op(bus.funct3, bus.funct7[5], bus.funct7[5]);
                    reg_write_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only funct7[5] distinguishes the RV32I base ops.
    logic unused_funct7;
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    assign bus.alu_control      = alu_d;
    assign bus.alu_src_a_sel    = src_a_d;
    assign bus.alu_src_b_sel    = src_b_d;
    assign bus.reg_write_enable = reg_write_d;
    assign bus.mem_read         = mem_read_d;
    assign bus.mem_write        = mem_write_d;
    assign bus.mem_size         = mem_size_d;
    assign bus.mem_usign_load   = usign_d;
    assign bus.imm_src          = imm_d;
    assign bus.pc_src           = pc_src_d;
    assign bus.result_src       = result_d;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_unit_if cu_if();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cu_if)
    );

    typedef struct packed {
        alu_op_e         alu;
        alu_src_a_e      src_a;
        alu_src_b_e      src_b;
        logic            rw;
        logic            mr;
        logic            mw;
        mem_size_e       sz;
        logic            us;
        immediate_type_e imm;
        pc_src_e         pc;
        result_src_e     res;
    } ctrl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] flg;   // {zero, negative, carry, overflow}
        ctrl_t      exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic ctrl_t cfg(alu_op_e alu, alu_src_a_e a, alu_src_b_e b,
                                  logic rw, logic mr, logic mw, mem_size_e sz,
                                  logic us, immediate_type_e imm, pc_src_e pc,
                                  result_src_e res);
        ctrl_t c;
        c.alu = alu; c.src_a = a; c.src_b = b; c.rw = rw; c.mr = mr; c.mw = mw;
        c.sz = sz; c.us = us; c.imm = imm; c.pc = pc; c.res = res;
        return c;
    endfunction

    function automatic ctrl_t nop();
        return cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0,
                   IMM_I, PC_SRC_PC4, RESULT_SRC_ALU);
    endfunction

    // Reference decode: branch outcome from real operand comparisons,
    // ALU op and load width from lookup tables.
    function automatic ctrl_t model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                    logic [31:0] rs1, logic [31:0] rs2);
        ctrl_t   r = nop();
        alu_op_e tbl [8];
        logic    take [8];
        alu_op_e a;
        mem_size_e sizes [4];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        sizes = '{MEM_BYTE, MEM_HALF, MEM_WORD, MEM_WORD};
        take[0] = (rs1 == rs2);
        take[1] = (rs1 != rs2);
        take[2] = 1'b0;
        take[3] = 1'b0;
        take[4] = ($signed(rs1) <  $signed(rs2));
        take[5] = ($signed(rs1) >= $signed(rs2));
        take[6] = (rs1 <  rs2);
        take[7] = (rs1 >= rs2);
        case (op)
            OPCODE_LUI:   r = cfg(ALU_ADD, ALU_SRC_A_ZERO, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_U, PC_SRC_PC4, RESULT_SRC_ALU);
            OPCODE_AUIPC: r = cfg(ALU_AUIPC, ALU_SRC_A_PC, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_U, PC_SRC_PC4, RESULT_SRC_ALU);
            OPCODE_JAL:   r = cfg(ALU_ADD, ALU_SRC_A_PC, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_J, PC_SRC_BRANCH_JAL, RESULT_SRC_PC4);
            OPCODE_JALR:  r = cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_JALR, RESULT_SRC_PC4);
            OPCODE_BRANCH: r = cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B,
                                   take[f3] ? PC_SRC_BRANCH_JAL : PC_SRC_PC4, RESULT_SRC_ALU);
            OPCODE_LOAD:
                if (f3 != 3 && f3 != 6 && f3 != 7)
                    r = cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 1, 0, sizes[f3[1:0]], f3[2], IMM_I, PC_SRC_PC4, RESULT_SRC_MEM);
            OPCODE_STORE:
                if (f3 <= 2)
                    r = cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 0, 0, 1, sizes[f3[1:0]], 0, IMM_S, PC_SRC_PC4, RESULT_SRC_ALU);
            OPCODE_OP_IMM: begin
                a = tbl[f3];
                if (f3 == 5 && f7[5]) a = ALU_SRA;
                r = cfg(a, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU);
            end
            OPCODE_OP: begin
                a = tbl[f3];
                if (f3 == 5 && f7[5]) a = ALU_SRA;
                if (f3 == 0 && f7[5]) a = ALU_SUB;
                r = cfg(a, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU);
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic ctrl_t sample();
        return {cu_if.alu_control, cu_if.alu_src_a_sel, cu_if.alu_src_b_sel,
                cu_if.reg_write_enable, cu_if.mem_read, cu_if.mem_write,
                cu_if.mem_size, cu_if.mem_usign_load, cu_if.imm_src,
                cu_if.pc_src, cu_if.result_src};
    endfunction

    task automatic check(input string name, input ctrl_t exp);
        ctrl_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [3:0] flg);
        cu_if.opcode        = op;
        cu_if.funct3        = f3;
        cu_if.funct7        = f7;
        cu_if.zero_flag     = flg[3];
        cu_if.negative_flag = flg[2];
        cu_if.carry_flag    = flg[1];
        cu_if.overflow_flag = flg[0];
    endtask

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] flg,
                           input ctrl_t exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.flg = flg; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] rs1, rs2, diff;
        logic [3:0]  flg;
        logic [6:0]  op, f7;
        logic [2:0]  f3;

        // Directed table
        add_vec(OPCODE_LUI, 3'd0, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_ZERO, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_U, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_BRANCH, F3_BEQ, 7'd0, 4'b1000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_BRANCH_JAL, RESULT_SRC_ALU));
        add_vec(OPCODE_BRANCH, F3_BEQ, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_LOAD, F3_LW, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 1, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_MEM));
        add_vec(OPCODE_LOAD, F3_LBU, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 1, 0, MEM_BYTE, 1, IMM_I, PC_SRC_PC4, RESULT_SRC_MEM));
        add_vec(OPCODE_LOAD, F3_LH, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 1, 0, MEM_HALF, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_MEM));
        add_vec(OPCODE_JALR, 3'd0, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_JALR, RESULT_SRC_PC4));
        add_vec(OPCODE_OP, F3_SR, 7'b0100000, 4'b0000,
                cfg(ALU_SRA, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_STORE, F3_SW, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 0, 0, 1, MEM_WORD, 0, IMM_S, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_STORE, F3_SH, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 0, 0, 1, MEM_HALF, 0, IMM_S, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_AUIPC, 3'd0, 7'd0, 4'b0000,
                cfg(ALU_AUIPC, ALU_SRC_A_PC, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_U, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_JAL, 3'd0, 7'd0, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_PC, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_J, PC_SRC_BRANCH_JAL, RESULT_SRC_PC4));
        add_vec(OPCODE_LOAD, 3'b011, 7'd0, 4'b0000, nop());
        add_vec(OPCODE_STORE, 3'b100, 7'd0, 4'b0000, nop());
        add_vec(7'b1111111, 3'd0, 7'd0, 4'b1111, nop());
        add_vec(OPCODE_BRANCH, F3_BLT, 7'd0, 4'b0100,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_BRANCH_JAL, RESULT_SRC_ALU));
        add_vec(OPCODE_BRANCH, F3_BLT, 7'd0, 4'b0101,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_BRANCH, F3_BGEU, 7'd0, 4'b0010,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_BRANCH, 3'b010, 7'd0, 4'b1111,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 0, 0, 0, MEM_WORD, 0, IMM_B, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_OP_IMM, F3_ADD, 7'b0100000, 4'b0000,
                cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_OP, F3_ADD, 7'b0100000, 4'b0000,
                cfg(ALU_SUB, ALU_SRC_A_RS1, ALU_SRC_B_RS2, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU));
        add_vec(OPCODE_OP_IMM, F3_SR, 7'b0100000, 4'b0000,
                cfg(ALU_SRA, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 1, 0, 0, MEM_WORD, 0, IMM_I, PC_SRC_PC4, RESULT_SRC_ALU));

        // Reset held with a store on the bus: nothing may fire.
        drive(OPCODE_STORE, F3_SW, 7'd0, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_store_nop", nop());
        drive(OPCODE_LUI, 3'd0, 7'd0, 4'b0000);
        #1 check("reset_lui_nop", nop());

        // Release: still NOP until the first edge with rst_n high.
        drive(OPCODE_STORE, F3_SW, 7'd0, 4'b0000);
        rst_n = 1'b1;
        #1 check("release_before_edge", nop());
        @(posedge clk);
        #1 check("release_after_edge",
                 cfg(ALU_ADD, ALU_SRC_A_RS1, ALU_SRC_B_IMM, 0, 0, 1, MEM_WORD, 0, IMM_S, PC_SRC_PC4, RESULT_SRC_ALU));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].flg);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Mid-instruction reset: decode holds until the edge, then NOP.
        @(negedge clk);
        drive(OPCODE_JAL, 3'd0, 7'd0, 4'b0000);
        rst_n = 1'b0;
        #1 check("midreset_before_edge", model(OPCODE_JAL, 3'd0, 7'd0, 32'd0, 32'd0));
        @(posedge clk);
        #1 check("midreset_after_edge", nop());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("midreset_recover", model(OPCODE_JAL, 3'd0, 7'd0, 32'd0, 32'd0));

        // Randomized decode against the reference model.
        ops = '{OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
                OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP, 7'd0};
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            op = ops[$urandom_range(0, 9)];
            if (op == 7'd0) op = 7'($urandom);
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            if ($urandom_range(0, 3) == 0) rs2 = {~rs1[31], rs2[30:0]};
            diff = rs1 - rs2;
            flg[3] = (diff == 32'd0);
            flg[2] = diff[31];
            flg[1] = (rs1 < rs2);
            flg[0] = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
            drive(op, f3, f7, flg);
            #1 check($sformatf("rand%0d op=%b f3=%0d", n, op, f3), model(op, f3, f7, rs1, rs2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
